// File: rtl/set_pkg.sv
// Shared types and constants for the SET command dispatcher.
package set_pkg;

    localparam logic [1:0] MODE_A            = 2'b00;
    localparam logic [1:0] MODE_AND          = 2'b01;
    localparam logic [1:0] MODE_XOR          = 2'b10;
    localparam logic [1:0] MODE_TWO_OF_THREE = 2'b11;

    typedef struct packed {
        logic [23:0] central;
        logic [11:0] radius;
        logic [1:0]  mode;
    } set_cmd_t;

    localparam int CMD_W = $bits(set_cmd_t);

    // Dispatcher FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_OUT   = 2'd3;

endpackage

// File: rtl/set_cmd_fifo.sv
// Synchronous FIFO with occupancy count; caller guarantees no push when full
// and no pop when empty. rdata shows the head entry combinationally.
module set_cmd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/set_cmd_dispatcher.sv
// Command front-end for the SET candidate engine: queues commands, issues one job
// at a time, returns tagged results. Optional watchdog: SET_DISPATCH_TIMEOUT_EN.
module set_cmd_dispatcher
    import set_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [23:0]            cmd_central,
    input  logic [11:0]            cmd_radius,
    input  logic [1:0]             cmd_mode,
    input  logic [TAG_W-1:0]       cmd_tag,
    output logic                   set_en,
    output logic [23:0]            set_central,
    output logic [11:0]            set_radius,
    output logic [1:0]             set_mode,
    input  logic                   set_valid,
    input  logic [7:0]             set_candidate,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [7:0]             res_candidate,
    output logic [TAG_W-1:0]       res_tag,
    output logic [1:0]             res_mode,
    output logic                   res_timeout,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int ENT_W = CMD_W + TAG_W;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("set_cmd_dispatcher: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
    end

    logic             push, pop;
    logic [ENT_W-1:0] fifo_wdata, fifo_rdata;
    set_cmd_t         head_cmd;
    logic [TAG_W-1:0] head_tag;

    state_t           state_q, state_d;
    set_cmd_t         op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [7:0]       cand_q, cand_d;

    assign cmd_ready  = (fifo_count != CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == ST_IDLE) && (fifo_count != '0);
    assign fifo_wdata = {cmd_central, cmd_radius, cmd_mode, cmd_tag};
    assign head_cmd   = fifo_rdata[ENT_W-1:TAG_W];
    assign head_tag   = fifo_rdata[TAG_W-1:0];

    set_cmd_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

`ifdef SET_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          tmo_q, tmo_d;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tag_d   = tag_q;
        cand_d  = cand_q;
`ifdef SET_DISPATCH_TIMEOUT_EN
        wcnt_d  = wcnt_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    op_d    = head_cmd;
                    tag_d   = head_tag;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef SET_DISPATCH_TIMEOUT_EN
                wcnt_d  = '0;
`endif
            end
            ST_WAIT: begin
                // A real result wins over a watchdog expiry in the same cycle.
                if (set_valid) begin
                    cand_d  = set_candidate;
                    state_d = ST_OUT;
`ifdef SET_DISPATCH_TIMEOUT_EN
                    tmo_d   = 1'b0;
                end else if (wcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    cand_d  = '0;
                    tmo_d   = 1'b1;
                    state_d = ST_OUT;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
`endif
                end
            end
            ST_OUT: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            tag_q   <= '0;
            cand_q  <= '0;
`ifdef SET_DISPATCH_TIMEOUT_EN
            wcnt_q  <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            cand_q  <= cand_d;
`ifdef SET_DISPATCH_TIMEOUT_EN
            wcnt_q  <= wcnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign set_en        = (state_q == ST_ISSUE);
    assign res_valid     = (state_q == ST_OUT);
    assign set_central   = op_q.central;
    assign set_radius    = op_q.radius;
    assign set_mode      = op_q.mode;
    assign res_candidate = cand_q;
    assign res_tag       = tag_q;
    assign res_mode      = op_q.mode;
`ifdef SET_DISPATCH_TIMEOUT_EN
    assign res_timeout   = tmo_q;
`else
    assign res_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_set_cmd_dispatcher.sv
// Directed self-checking bench for set_cmd_dispatcher with a behavioural engine model.
// The watchdog scenario runs only when SET_DISPATCH_TIMEOUT_EN is defined.
module tb_set_cmd_dispatcher;

    localparam int DEPTH       = 4;
    localparam int TAG_W       = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int CW          = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [23:0]      cmd_central;
    logic [11:0]      cmd_radius;
    logic [1:0]       cmd_mode;
    logic [TAG_W-1:0] cmd_tag;
    logic             set_en;
    logic [23:0]      set_central;
    logic [11:0]      set_radius;
    logic [1:0]       set_mode;
    logic             set_valid;
    logic [7:0]       set_candidate;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_candidate;
    logic [TAG_W-1:0] res_tag;
    logic [1:0]       res_mode;
    logic             res_timeout;
    logic [CW-1:0]    fifo_count;

    set_cmd_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_central(cmd_central),
        .cmd_radius(cmd_radius), .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
        .set_valid(set_valid), .set_candidate(set_candidate),
        .res_valid(res_valid), .res_ready(res_ready), .res_candidate(res_candidate),
        .res_tag(res_tag), .res_mode(res_mode), .res_timeout(res_timeout),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Engine model: answers each en after eng_delay cycles with eng_cand + central[7:0].
    int         eng_delay = 390;
    logic       eng_auto  = 1'b1;
    logic [7:0] eng_cand  = 8'h15;
    int         spur_req  = 0;
    int         en_count  = 0;

    initial begin : engine
        int         left;
        int         spur_done;
        logic [7:0] pend;
        left = 0; spur_done = 0; pend = '0;
        set_valid = 1'b0; set_candidate = '0;
        forever begin
            @(negedge clk);
            set_valid = 1'b0;
            if (rst) begin
                left = 0;
            end else begin
                if (left > 0) begin
                    left--;
                    if (left == 0) begin
                        set_valid = 1'b1;
                        set_candidate = pend;
                    end
                end
                if (spur_done != spur_req) begin
                    spur_done = spur_req;
                    set_valid = 1'b1;
                    set_candidate = 8'hEE;
                end
                if (set_en) begin
                    en_count++;
                    if (eng_auto) begin
                        left = eng_delay;
                        pend = eng_cand + set_central[7:0];
                    end
                end
            end
        end
    end

    logic [TAG_W-1:0] got_tag[$];
    logic [7:0]       got_cand[$];
    int               rv_cycles = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst && res_valid) begin
                rv_cycles++;
                if (res_ready) begin
                    got_tag.push_back(res_tag);
                    got_cand.push_back(res_candidate);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int i, g, base, en_base, rv_base;

        rst = 1'b1; cmd_valid = 1'b0; cmd_central = '0; cmd_radius = '0;
        cmd_mode = '0; cmd_tag = '0; res_ready = 1'b0;
        repeat (3) tick();
        check("rst_ctrl", {set_en, res_valid, res_timeout, fifo_count}, '0);
        check("rst_ops", {set_central, set_radius, set_mode}, '0);
        check("rst_res", {res_candidate, res_tag, res_mode}, '0);
        check("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        tick();

        // Single job, mode AND, tag 3, engine answers 390 cycles after en.
        en_base = en_count; base = got_tag.size();
        eng_delay = 390; eng_cand = 8'h15;
        cmd_valid = 1'b1; cmd_central = 24'h123400; cmd_radius = 12'hABC;
        cmd_mode = 2'b01; cmd_tag = 4'd3;
        check("t1_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("t1_count", fifo_count, 1);
        check("t1_no_early_en", set_en, 0);
        tick();
        check("t1_en_latency", set_en, 1);
        check("t1_operands", {set_central, set_radius, set_mode}, {24'h123400, 12'hABC, 2'b01});
        check("t1_popped", fifo_count, 0);
        tick();
        check("t1_en_single", set_en, 0);
        i = 0;
        while (!res_valid && i < 1000) begin tick(); i++; end
        check("t1_res_latency", i, 390);
        check("t1_result", {res_timeout, res_candidate, res_tag, res_mode}, {1'b0, 8'h15, 4'd3, 2'b01});
        res_ready = 1'b1;
        tick();
        check("t1_res_drop", res_valid, 0);
        check("t1_res_count", got_tag.size() - base, 1);
        check("t1_en_count", en_count - en_base, 1);

        // Burst of 6 commands; FIFO fills, results return in order.
        en_base = en_count; base = got_tag.size();
        eng_delay = 10; eng_cand = 8'h80;
        for (int k = 0; k < 6; k++) begin
            cmd_valid = 1'b1; cmd_tag = TAG_W'(k); cmd_central = {16'h0, 8'(k)};
            cmd_radius = 12'h111; cmd_mode = 2'(k);
            g = 0;
            while (!cmd_ready && g < 100) begin tick(); g++; end
            check("t2_accept_bound", g < 100, 1);
            tick();
            if (k == 4) begin
                check("t2_full_count", fifo_count, 4);
                check("t2_ready_low", cmd_ready, 0);
            end
        end
        cmd_valid = 1'b0;
        g = 0;
        while (got_tag.size() < base + 6 && g < 2000) begin tick(); g++; end
        check("t2_res_count", got_tag.size() - base, 6);
        for (int k = 0; k < 6; k++) begin
            check("t2_tag", got_tag[base + k], k);
            check("t2_cand", got_cand[base + k], 8'h80 + k);
        end
        tick();
        check("t2_en_count", en_count - en_base, 6);

        // Host stalls 20 cycles: result held, no new job, FIFO keeps filling.
        res_ready = 1'b0; base = got_tag.size();
        eng_delay = 3; eng_cand = 8'h30;
        cmd_valid = 1'b1; cmd_tag = 4'd6; cmd_central = 24'h000005; cmd_mode = 2'b10;
        tick();
        cmd_valid = 1'b0;
        g = 0;
        while (!res_valid && g < 100) begin tick(); g++; end
        en_base = en_count;
        for (int c = 0; c < 20; c++) begin
            cmd_valid = (c < 2); cmd_tag = TAG_W'(7 + c); cmd_central = {16'h0, 8'(c)};
            check("t3_hold", {res_valid, res_timeout, res_candidate, res_tag, res_mode},
                  {1'b1, 1'b0, 8'h35, 4'd6, 2'b10});
            tick();
        end
        cmd_valid = 1'b0;
        check("t3_no_en", en_count - en_base, 0);
        check("t3_fifo_filled", fifo_count, 2);
        res_ready = 1'b1;
        i = 0;
        do begin tick(); i++; end while (!set_en && i < 6);
        check("t3_restart", i, 2);
        g = 0;
        while (got_tag.size() < base + 3 && g < 500) begin tick(); g++; end
        check("t3_tags", {got_tag[base], got_tag[base + 1], got_tag[base + 2]}, {4'd6, 4'd7, 4'd8});
        tick();

        // Operand stability while cmd_* toggle; spurious strobes in OUT and IDLE.
        eng_delay = 30; eng_cand = 8'h00;
        cmd_valid = 1'b1; cmd_central = 24'hA5C3F0; cmd_radius = 12'h5A5;
        cmd_mode = 2'b11; cmd_tag = 4'd9;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("t4_en", set_en, 1);
        for (int c = 0; c < 20; c++) begin
            cmd_central = 24'($urandom); cmd_radius = 12'($urandom);
            cmd_mode = 2'($urandom); cmd_tag = TAG_W'($urandom);
            tick();
            check("t4_operands", {set_central, set_radius, set_mode}, {24'hA5C3F0, 12'h5A5, 2'b11});
        end
        res_ready = 1'b0;
        g = 0;
        while (!res_valid && g < 100) begin tick(); g++; end
        check("t4_cand", res_candidate, 8'hF0);
        spur_req++;
        repeat (3) tick();
        check("t4_spur_out", {res_valid, res_candidate, res_tag}, {1'b1, 8'hF0, 4'd9});
        res_ready = 1'b1;
        tick();
        rv_base = rv_cycles; en_base = en_count;
        spur_req++;
        repeat (10) tick();
        check("t4_spur_idle_res", rv_cycles - rv_base, 0);
        check("t4_spur_idle_en", en_count - en_base, 0);
        check("t4_operands_held", {set_central, set_radius, set_mode}, {24'hA5C3F0, 12'h5A5, 2'b11});

`ifdef SET_DISPATCH_TIMEOUT_EN
        // Silent engine: watchdog fires after 16 WAIT cycles.
        eng_auto = 1'b0;
        cmd_valid = 1'b1; cmd_central = 24'h000002; cmd_tag = 4'd10; cmd_mode = 2'b00;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("t5_en", set_en, 1);
        i = 0;
        while (!res_valid && i < 100) begin tick(); i++; end
        check("t5_tmo_latency", i, 17);
        check("t5_tmo_result", {res_timeout, res_candidate, res_tag}, {1'b1, 8'h00, 4'd10});
        tick();
        // Engine answers exactly on the expiry cycle: normal result wins.
        eng_auto = 1'b1; eng_delay = 16; eng_cand = 8'h40;
        cmd_valid = 1'b1; cmd_tag = 4'd11;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("t5b_en", set_en, 1);
        i = 0;
        while (!res_valid && i < 100) begin tick(); i++; end
        check("t5b_latency", i, 17);
        check("t5b_result", {res_timeout, res_candidate, res_tag}, {1'b0, 8'h42, 4'd11});
        tick();
`endif

        // Reset during WAIT with two commands queued.
        eng_auto = 1'b1; eng_delay = 200; eng_cand = 8'h00;
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1; cmd_tag = TAG_W'(12 + k); cmd_central = {16'h0, 8'(k)};
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        check("t6_queued", fifo_count, 2);
        rst = 1'b1;
        #1;
        check("t6_rst_ctrl", {set_en, res_valid, res_timeout, fifo_count}, '0);
        tick();
        check("t6_rst_ops", {set_central, set_radius, set_mode, res_candidate, res_tag, res_mode}, '0);
        check("t6_rst_ctrl_next", {set_en, res_valid, fifo_count}, '0);
        rst = 1'b0;
        tick();
        rv_base = rv_cycles; en_base = en_count;
        repeat (250) tick();
        check("t6_no_result", rv_cycles - rv_base, 0);
        check("t6_no_en", en_count - en_base, 0);
        check("t6_fifo_empty", fifo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
